// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one fixed-latency memory between the fetch
// port and the load/store port, with data priority bounded by a starvation count.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 3,
  parameter int unsigned MAX_IWAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_valid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STV_W = $clog2(MAX_IWAIT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_IWAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             store_q;
  logic             if_elig, d_elig;
  logic             grant_i, grant_d;
  logic             done;

  // Grant decision and next-state; a requester in its completion cycle is not eligible
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    if_elig  = if_req_i & ~if_valid_o;
    d_elig   = d_req_i & ~d_valid_o;
    case (state_q)
      IDLE: begin
        if (!rst_i) begin
          if (if_elig && d_elig) begin
            if (starve_q == STV_MAX) grant_i = 1'b1;
            else                     grant_d = 1'b1;
          end else begin
            grant_i = if_elig;
            grant_d = d_elig;
          end
        end
        if (grant_i) begin
          state_d  = BUSY_I;
          lat_d    = LAT_LOAD;
          starve_d = '0;
        end else if (grant_d) begin
          state_d = BUSY_D;
          lat_d   = LAT_LOAD;
          if (if_req_i && (starve_q != STV_MAX)) starve_d = starve_q + STV_W'(1);
        end
      end
      BUSY_I, BUSY_D: begin
        if (lat_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_gnt_o = grant_i;
  assign d_gnt_o  = grant_d;

  // Access sequencing: address/data capture at grant, response capture at the last busy cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      store_q     <= 1'b0;
      if_valid_o  <= 1'b0;
      d_valid_o   <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_data_o   <= '0;
      d_rdata_o   <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_valid_o <= done && (state_q == BUSY_I);
      d_valid_o  <= done && (state_q == BUSY_D);
      mem_we_o   <= grant_d & d_we_i;
      if (grant_i || grant_d) mem_en_o <= 1'b1;
      else if (done)          mem_en_o <= 1'b0;
      if (grant_i) begin
        mem_addr_o <= if_addr_i;
        store_q    <= 1'b0;
      end else if (grant_d) begin
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        store_q     <= d_we_i;
      end
      if (done && (state_q == BUSY_I))             if_data_o <= mem_rdata_i;
      if (done && (state_q == BUSY_D) && !store_q) d_rdata_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-3 instance with a scoreboard of expected responses,
// plus a latency-1 instance for the short-latency back-to-back case.
module tb_mem_arbiter;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A (latency 3)
  logic        a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic        a_if_gnt, a_if_valid, a_d_gnt, a_d_valid, a_mem_en, a_mem_we;
  logic [31:0] a_if_data, a_d_rdata, a_mem_addr, a_mem_wdata;

  // instance B (latency 1)
  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we;
  logic [31:0] b_if_data, b_d_rdata, b_mem_addr, b_mem_wdata;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_A), .MAX_IWAIT(4)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_valid_o(a_if_valid), .if_data_o(a_if_data),
    .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
    .d_gnt_o(a_d_gnt), .d_valid_o(a_d_valid), .d_rdata_o(a_d_rdata),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_B), .MAX_IWAIT(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_valid_o(b_if_valid), .if_data_o(b_if_data),
    .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
    .d_gnt_o(b_d_gnt), .d_valid_o(b_d_valid), .d_rdata_o(b_d_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory A: read data is only meaningful in the LAT_A-th busy cycle
  logic [31:0] a_mem [0:63];
  int          a_cnt = 0;
  always @(posedge clk) begin
    a_cnt <= a_mem_en ? a_cnt + 1 : 0;
    if (a_mem_we) a_mem[a_mem_addr[7:2]] <= a_mem_wdata;
  end
  assign a_mem_rdata = (a_mem_en && (a_cnt == LAT_A - 1)) ? a_mem[a_mem_addr[7:2]] : 32'hBAD0_BAD0;

  assign b_mem_rdata = b_mem_en ? ((b_mem_addr ^ 32'h5A5A_0000) + 32'h11) : 32'hBAD0_BAD0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          st;
  } exp_t;

  exp_t        sb_i[$];
  exp_t        sb_d[$];
  logic [31:0] exp_ifd, exp_drd;

  task automatic push_i(input logic [31:0] addr);
    exp_t e;
    e.data = a_mem[addr[7:2]];
    e.cyc  = cyc + LAT_A + 1;
    e.st   = 1'b0;
    sb_i.push_back(e);
  endtask

  task automatic push_d(input bit st, input logic [31:0] addr);
    exp_t e;
    e.data = st ? 32'h0 : a_mem[addr[7:2]];
    e.cyc  = cyc + LAT_A + 1;
    e.st   = st;
    sb_d.push_back(e);
  endtask

  // sel: 0 if_gnt, 1 d_gnt, 2 if_valid, 3 d_valid
  task automatic wait_ev(input int sel, input string name);
    bit hit = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      case (sel)
        0:       hit = a_if_gnt;
        1:       hit = a_d_gnt;
        2:       hit = a_if_valid;
        3:       hit = a_d_valid;
        default: hit = 1'b0;
      endcase
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: event not seen, required within 40 cycles", name);
    end
  endtask

  // Per-cycle invariants and response scoreboard for instance A
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_i.delete();
        sb_d.delete();
        exp_ifd = '0;
        exp_drd = '0;
      end else begin
        n_tests++;
        if (a_if_gnt && a_d_gnt) begin
          n_fail++; $display("FAIL gnt_mutex: both grants high at cycle %0d", cyc);
        end
        n_tests++;
        if ((a_if_gnt || a_d_gnt) && a_mem_en) begin
          n_fail++; $display("FAIL gnt_busy: grant with mem_en=1 at cycle %0d", cyc);
        end
        n_tests++;
        if (a_if_valid && a_d_valid) begin
          n_fail++; $display("FAIL valid_mutex: both valids high at cycle %0d", cyc);
        end
        if (a_if_valid) begin
          n_tests++;
          if (sb_i.size() == 0) begin
            n_fail++; $display("FAIL if_valid_unexpected: pulse at cycle %0d, required none", cyc);
          end else begin
            e = sb_i.pop_front();
            exp_ifd = e.data;
            if (a_if_data !== e.data) begin
              n_fail++; $display("FAIL if_data: got %h, required %h", a_if_data, e.data);
            end
            n_tests++;
            if (cyc != e.cyc) begin
              n_fail++; $display("FAIL if_valid_cycle: got %0d, required %0d", cyc, e.cyc);
            end
          end
        end
        if (a_d_valid) begin
          n_tests++;
          if (sb_d.size() == 0) begin
            n_fail++; $display("FAIL d_valid_unexpected: pulse at cycle %0d, required none", cyc);
          end else begin
            e = sb_d.pop_front();
            if (!e.st) exp_drd = e.data;
            if (a_d_rdata !== exp_drd) begin
              n_fail++; $display("FAIL d_rdata: got %h, required %h", a_d_rdata, exp_drd);
            end
            n_tests++;
            if (a_if_data !== exp_ifd) begin
              n_fail++; $display("FAIL if_data_hold: got %h, required %h", a_if_data, exp_ifd);
            end
            n_tests++;
            if (cyc != e.cyc) begin
              n_fail++; $display("FAIL d_valid_cycle: got %0d, required %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({a_if_gnt, a_d_gnt, a_if_valid, a_d_valid, a_mem_en, a_mem_we,
         a_mem_addr, a_mem_wdata, a_if_data, a_d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs not zero (addr %h wdata %h ifd %h drd %h), required all 0",
                         a_mem_addr, a_mem_wdata, a_if_data, a_d_rdata);
    end
    n_tests++;
    if ({b_if_gnt, b_d_gnt, b_if_valid, b_d_valid, b_mem_en, b_mem_we,
         b_mem_addr, b_mem_wdata, b_if_data, b_d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs not zero (addr %h wdata %h ifd %h drd %h), required all 0",
                         b_mem_addr, b_mem_wdata, b_if_data, b_d_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Back-to-back stores with the request held through each valid cycle
  task automatic test_preload();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      a_d_req = 1'b1; a_d_we = 1'b1;
      a_d_addr = 32'(i * 4); a_d_wdata = 32'hC0DE_0000 | 32'(i);
      wait_ev(1, "preload_gnt");
      push_d(1'b1, a_d_addr);
      wait_ev(3, "preload_valid");
    end
    @(posedge clk); #1;
    a_d_req = 1'b0; a_d_we = 1'b0;
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = addr; a_d_wdata = data;
    wait_ev(1, "store_gnt");
    push_d(1'b1, addr);
    for (int k = 1; k <= LAT_A; k++) begin
      @(negedge clk);
      n_tests++;
      if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, k == 1, addr, data}) begin
        n_fail++; $display("FAIL store_busy_c%0d: en=%b we=%b addr=%h wdata=%h, required en=1 we=%b addr=%h wdata=%h",
                           k, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, k == 1, addr, data);
      end
    end
    wait_ev(3, "store_valid");
    @(posedge clk); #1;
    a_d_req = 1'b0; a_d_we = 1'b0;
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [31:0] want);
    @(posedge clk); #1;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = addr;
    wait_ev(1, "load_gnt");
    push_d(1'b0, addr);
    for (int k = 1; k <= LAT_A; k++) begin
      @(negedge clk);
      n_tests++;
      if ({a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, addr}) begin
        n_fail++; $display("FAIL load_busy_c%0d: en=%b we=%b addr=%h, required en=1 we=0 addr=%h",
                           k, a_mem_en, a_mem_we, a_mem_addr, addr);
      end
    end
    wait_ev(3, "load_valid");
    n_tests++;
    if (a_d_rdata !== want) begin
      n_fail++; $display("FAIL load_word: got %h, required %h", a_d_rdata, want);
    end
    @(posedge clk); #1;
    a_d_req = 1'b0;
  endtask

  // Fetch still requesting in its valid cycle must not be re-granted; data goes instead
  task automatic test_regrant();
    @(posedge clk); #1;
    a_if_req = 1'b1; a_if_addr = 32'h20;
    wait_ev(0, "rg_if_gnt");
    push_i(32'h20);
    @(posedge clk); #1;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h24;
    wait_ev(2, "rg_if_valid");
    n_tests++;
    if ({a_if_gnt, a_d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL regrant: if_gnt=%b d_gnt=%b in valid cycle, required 0 1", a_if_gnt, a_d_gnt);
    end
    if (a_d_gnt) push_d(1'b0, 32'h24);
    @(posedge clk); #1;
    a_if_req = 1'b0;
    wait_ev(3, "rg_d_valid");
    @(posedge clk); #1;
    a_d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    a_if_req = 1'b1; a_if_addr = 32'h08;
    wait_ev(0, "rm_gnt");
    push_i(32'h08);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({a_if_gnt, a_d_gnt, a_if_valid, a_d_valid, a_mem_en, a_mem_we,
         a_mem_addr, a_mem_wdata, a_if_data, a_d_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid: en=%b valid=%b addr=%h, required all outputs 0",
                         a_mem_en, a_if_valid, a_mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_regnt: if_gnt=%b, required 1", a_if_gnt);
    end else begin
      push_i(32'h08);
    end
    wait_ev(2, "rm_valid");
    @(posedge clk); #1;
    a_if_req = 1'b0;
  endtask

  // Fetch withdraws after each lost round; the fifth contested round must go to fetch
  task automatic test_starve();
    bit exp_i;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      a_if_req = 1'b1; a_if_addr = 32'h30;
      a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'(r * 4);
      exp_i = (r == 4);
      @(negedge clk);
      n_tests++;
      if ({a_if_gnt, a_d_gnt} !== {exp_i, ~exp_i}) begin
        n_fail++; $display("FAIL starve_round%0d: if_gnt=%b d_gnt=%b, required %b %b",
                           r, a_if_gnt, a_d_gnt, exp_i, ~exp_i);
      end
      if (a_if_gnt) push_i(32'h30);
      if (a_d_gnt)  push_d(1'b0, a_d_addr);
      @(posedge clk); #1;
      if (exp_i) a_d_req = 1'b0;
      else       a_if_req = 1'b0;
      wait_ev(exp_i ? 2 : 3, "starve_valid");
      @(posedge clk); #1;
      a_if_req = 1'b0; a_d_req = 1'b0;
    end
  endtask

  // Latency-1 instance: fetch to 0x0 then 0x4
  task automatic test_lat1();
    @(posedge clk); #1;
    b_if_req = 1'b1; b_if_addr = 32'h0;
    @(negedge clk);
    n_tests++;
    if (b_if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL lat1_gnt0: got %b, required 1", b_if_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b_mem_en, b_mem_addr, b_if_gnt, b_if_valid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lat1_busy0: en=%b addr=%h gnt=%b valid=%b, required 1 0 0 0",
                         b_mem_en, b_mem_addr, b_if_gnt, b_if_valid);
    end
    @(posedge clk); #1;
    b_if_addr = 32'h4;
    @(negedge clk);
    n_tests++;
    if ({b_if_valid, b_if_gnt, b_mem_en, b_if_data} !== {1'b1, 1'b0, 1'b0, 32'h5A5A_0011}) begin
      n_fail++; $display("FAIL lat1_valid0: valid=%b gnt=%b en=%b data=%h, required 1 0 0 5a5a0011",
                         b_if_valid, b_if_gnt, b_mem_en, b_if_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b_if_gnt, b_if_valid} !== 2'b10) begin
      n_fail++; $display("FAIL lat1_gnt1: gnt=%b valid=%b, required 1 0", b_if_gnt, b_if_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL lat1_busy1: en=%b addr=%h, required 1 00000004", b_mem_en, b_mem_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b_if_valid, b_if_data, b_d_valid, b_d_gnt} !== {1'b1, 32'h5A5A_0015, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lat1_valid1: valid=%b data=%h, required 1 5a5a0015", b_if_valid, b_if_data);
    end
    @(posedge clk); #1;
    b_if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_preload();
    test_store(32'h10, 32'h0000_1234);
    test_store(32'h40, 32'hDEAD_BEEF);
    test_load(32'h40, 32'hDEAD_BEEF);
    test_load(32'h10, 32'h0000_1234);
    test_regrant();
    test_reset_mid();
    test_starve();
    test_lat1();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ((sb_i.size() + sb_d.size()) != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_i.size() + sb_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
